// File: rtl/mem_req_demux2.sv
// mem_req_demux2: routes an in-order request stream to port A (cached) or port B (uncached/MMIO)
// by address and merges the two response streams back in order. Define DEMUX_ERR_EN for err.
module mem_req_demux2 #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              DEPTH   = 4,
  parameter logic [AW-1:0]   B_MASK  = 32'hE000_0000,
  parameter logic [AW-1:0]   B_MATCH = 32'hA000_0000
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m_req_valid,
  output logic              m_req_ready,
  input  logic [AW-1:0]     m_req_addr,
  input  logic              m_req_wr,
  input  logic [DW/8-1:0]   m_req_wstrb,
  input  logic [DW-1:0]     m_req_wdata,
  output logic              m_rsp_valid,
  input  logic              m_rsp_ready,
  output logic [DW-1:0]     m_rsp_rdata,

  output logic              a_req_valid,
  input  logic              a_req_ready,
  output logic [AW-1:0]     a_req_addr,
  output logic              a_req_wr,
  output logic [DW/8-1:0]   a_req_wstrb,
  output logic [DW-1:0]     a_req_wdata,
  input  logic              a_rsp_valid,
  output logic              a_rsp_ready,
  input  logic [DW-1:0]     a_rsp_rdata,

  output logic              b_req_valid,
  input  logic              b_req_ready,
  output logic [AW-1:0]     b_req_addr,
  output logic              b_req_wr,
  output logic [DW/8-1:0]   b_req_wstrb,
  output logic [DW-1:0]     b_req_wdata,
  input  logic              b_rsp_valid,
  output logic              b_rsp_ready,
  input  logic [DW-1:0]     b_rsp_rdata,

  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             sel_b;
  logic             full;
  logic             not_empty;
  logic             accept;
  logic             pop;
  logic             head;
  logic [DEPTH-1:0] route_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign sel_b     = ((m_req_addr & B_MASK) == B_MATCH);
  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);

  // Request fields are broadcast; only the valid is steered.
  assign a_req_addr  = m_req_addr;
  assign a_req_wr    = m_req_wr;
  assign a_req_wstrb = m_req_wstrb;
  assign a_req_wdata = m_req_wdata;
  assign b_req_addr  = m_req_addr;
  assign b_req_wr    = m_req_wr;
  assign b_req_wstrb = m_req_wstrb;
  assign b_req_wdata = m_req_wdata;

  assign a_req_valid = m_req_valid & ~sel_b & ~full;
  assign b_req_valid = m_req_valid &  sel_b & ~full;
  assign m_req_ready = ~full & (sel_b ? b_req_ready : a_req_ready);
  assign accept      = m_req_valid & m_req_ready;

  // The oldest outstanding request decides which target may answer next.
  assign head        = route_q[rd_ptr];
  assign m_rsp_valid = not_empty & (head ? b_rsp_valid : a_rsp_valid);
  assign m_rsp_rdata = head ? b_rsp_rdata : a_rsp_rdata;
  assign a_rsp_ready = not_empty & ~head & m_rsp_ready;
  assign b_rsp_ready = not_empty &  head & m_rsp_ready;
  assign pop         = m_rsp_valid & m_rsp_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      route_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        route_q[wr_ptr] <= sel_b;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DEMUX_ERR_EN
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          err_q;
  logic          acc_a;
  logic          acc_b;
  logic          pop_a;
  logic          pop_b;

  assign acc_a = accept & ~sel_b;
  assign acc_b = accept &  sel_b;
  assign pop_a = a_rsp_valid & a_rsp_ready;
  assign pop_b = b_rsp_valid & b_rsp_ready;

  // A target answering while nothing is outstanding to it is a protocol violation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_a <= '0;
      cnt_b <= '0;
      err_q <= 1'b0;
    end else begin
      case ({acc_a, pop_a})
        2'b10:   cnt_a <= cnt_a + CW'(1);
        2'b01:   cnt_a <= cnt_a - CW'(1);
        default: cnt_a <= cnt_a;
      endcase
      case ({acc_b, pop_b})
        2'b10:   cnt_b <= cnt_b + CW'(1);
        2'b01:   cnt_b <= cnt_b - CW'(1);
        default: cnt_b <= cnt_b;
      endcase
      err_q <= err_q | (a_rsp_valid & (cnt_a == '0)) | (b_rsp_valid & (cnt_b == '0));
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_demux2.sv
// tb_mem_req_demux2: scenario tasks drive both target ports directly; expected response data is
// queued when each request is issued and compared as the merged stream delivers it.
module tb_mem_req_demux2;

  logic        clk;
  logic        resetn;
  logic        m_req_valid, m_req_ready, m_req_wr;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_rsp_valid, m_rsp_ready;
  logic [31:0] m_rsp_rdata;
  logic        a_req_valid, a_req_ready, a_req_wr;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_wstrb;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        err;

  logic [31:0] exp_q[$];
  int          n_pass;
  int          n_total;

  mem_req_demux2 dut (
    .clk(clk), .resetn(resetn),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wr(m_req_wr), .m_req_wstrb(m_req_wstrb), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .a_req_wr(a_req_wr), .a_req_wstrb(a_req_wstrb), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_req_wr(b_req_wr), .b_req_wstrb(b_req_wstrb), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    resetn = 1'b0;
    m_req_valid = 1'b0; m_req_addr = '0; m_req_wr = 1'b0; m_req_wstrb = '0; m_req_wdata = '0;
    m_rsp_ready = 1'b1;
    a_req_ready = 1'b1; a_rsp_valid = 1'b0; a_rsp_rdata = '0;
    b_req_ready = 1'b1; b_rsp_valid = 1'b0; b_rsp_rdata = '0;
    @(negedge clk);
    #1;
    n_total++;
    if (m_rsp_valid !== 1'b0) $display("[TB] FAIL reset_m_rsp_valid: got %0b want 0", m_rsp_valid);
    else n_pass++;
    n_total++;
    if ({a_rsp_ready, b_rsp_ready} !== 2'b00)
      $display("[TB] FAIL reset_rsp_ready: got %b want 00", {a_rsp_ready, b_rsp_ready});
    else n_pass++;
    n_total++;
    if ({a_req_valid, b_req_valid} !== 2'b00)
      $display("[TB] FAIL reset_req_valid: got %b want 00", {a_req_valid, b_req_valid});
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("[TB] FAIL reset_err: got %0b want 0", err);
    else n_pass++;
    n_total++;
    if (dut.count !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", dut.count);
    else n_pass++;
    n_total++;
    if (m_req_ready !== 1'b1) $display("[TB] FAIL reset_ready_no_valid: got %0b want 1", m_req_ready);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_order();
    logic [31:0] e;
    m_req_valid = 1'b1; m_req_wr = 1'b0; m_req_addr = 32'h0000_1000;
    #1;
    n_total++;
    if ({a_req_valid, b_req_valid, m_req_ready} !== 3'b101)
      $display("[TB] FAIL order_req_a: got %b want 101", {a_req_valid, b_req_valid, m_req_ready});
    else n_pass++;
    exp_q.push_back(32'h1111);
    @(negedge clk);
    m_req_addr = 32'hA000_0004;
    #1;
    n_total++;
    if ({a_req_valid, b_req_valid, m_req_ready} !== 3'b011)
      $display("[TB] FAIL order_req_b: got %b want 011", {a_req_valid, b_req_valid, m_req_ready});
    else n_pass++;
    exp_q.push_back(32'h2222);
    @(negedge clk);
    m_req_valid = 1'b0;
    b_rsp_valid = 1'b1; b_rsp_rdata = 32'h2222;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if ({b_rsp_ready, m_rsp_valid} !== 2'b00)
        $display("[TB] FAIL order_b_held: got %b want 00 (cycle %0d)", {b_rsp_ready, m_rsp_valid}, i);
      else n_pass++;
      @(negedge clk);
    end
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h1111;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== e)
      $display("[TB] FAIL order_first_rsp: got v=%0b d=%h want v=1 d=%h", m_rsp_valid, m_rsp_rdata, e);
    else n_pass++;
    n_total++;
    if ({a_rsp_ready, b_rsp_ready} !== 2'b10)
      $display("[TB] FAIL order_first_ready: got %b want 10", {a_rsp_ready, b_rsp_ready});
    else n_pass++;
    @(negedge clk);
    a_rsp_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== e)
      $display("[TB] FAIL order_second_rsp: got v=%0b d=%h want v=1 d=%h", m_rsp_valid, m_rsp_rdata, e);
    else n_pass++;
    n_total++;
    if (b_rsp_ready !== 1'b1) $display("[TB] FAIL order_b_ready: got %0b want 1", b_rsp_ready);
    else n_pass++;
    @(negedge clk);
    b_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd0) $display("[TB] FAIL order_drained: got %0d want 0", dut.count);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] e;
    m_req_valid = 1'b1; m_req_wr = 1'b0; m_req_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if (m_req_ready !== 1'b1) $display("[TB] FAIL full_accept: got %0b want 1 (req %0d)", m_req_ready, k);
      else n_pass++;
      exp_q.push_back(32'h100 + k);
      @(negedge clk);
    end
    #1;
    n_total++;
    if ({m_req_ready, a_req_valid} !== 2'b00)
      $display("[TB] FAIL full_blocked: got %b want 00", {m_req_ready, a_req_valid});
    else n_pass++;
    n_total++;
    if (dut.count !== 3'd4) $display("[TB] FAIL full_count: got %0d want 4", dut.count);
    else n_pass++;
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h100;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== e)
      $display("[TB] FAIL full_pop_rsp: got v=%0b d=%h want v=1 d=%h", m_rsp_valid, m_rsp_rdata, e);
    else n_pass++;
    n_total++;
    if (m_req_ready !== 1'b0) $display("[TB] FAIL full_no_pushthrough: got %0b want 0", m_req_ready);
    else n_pass++;
    @(negedge clk);
    a_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd3 || m_req_ready !== 1'b1)
      $display("[TB] FAIL full_reopen: got count=%0d ready=%0b want count=3 ready=1", dut.count, m_req_ready);
    else n_pass++;
    exp_q.push_back(32'h104);
    @(negedge clk);
    m_req_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd4) $display("[TB] FAIL full_refill: got %0d want 4", dut.count);
    else n_pass++;
    for (int k = 1; k < 5; k++) begin
      a_rsp_valid = 1'b1; a_rsp_rdata = 32'h100 + k;
      #1;
      e = exp_q.pop_front();
      n_total++;
      if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== e)
        $display("[TB] FAIL full_drain: got v=%0b d=%h want v=1 d=%h", m_rsp_valid, m_rsp_rdata, e);
      else n_pass++;
      @(negedge clk);
    end
    a_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd0) $display("[TB] FAIL full_empty: got %0d want 0", dut.count);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] e;
    m_req_valid = 1'b1; m_req_wr = 1'b1; m_req_addr = 32'hA000_0010;
    m_req_wstrb = 4'b0011; m_req_wdata = 32'hDEAD_BEEF;
    #1;
    n_total++;
    if ({a_req_valid, b_req_valid} !== 2'b01)
      $display("[TB] FAIL write_route: got %b want 01", {a_req_valid, b_req_valid});
    else n_pass++;
    n_total++;
    if ({b_req_addr, b_req_wr, b_req_wstrb, b_req_wdata} !== {32'hA000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF})
      $display("[TB] FAIL write_b_fields: got %h %0b %b %h want a0000010 1 0011 deadbeef",
               b_req_addr, b_req_wr, b_req_wstrb, b_req_wdata);
    else n_pass++;
    n_total++;
    if ({a_req_addr, a_req_wr, a_req_wstrb, a_req_wdata} !== {32'hA000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF})
      $display("[TB] FAIL write_a_fields: got %h %0b %b %h want a0000010 1 0011 deadbeef",
               a_req_addr, a_req_wr, a_req_wstrb, a_req_wdata);
    else n_pass++;
    exp_q.push_back(32'h0);
    @(negedge clk);
    m_req_valid = 1'b0; m_req_wr = 1'b0;
    b_rsp_valid = 1'b1; b_rsp_rdata = 32'h0;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== e || b_rsp_ready !== 1'b1)
      $display("[TB] FAIL write_rsp: got v=%0b d=%h rdy=%0b want v=1 d=%h rdy=1",
               m_rsp_valid, m_rsp_rdata, b_rsp_ready, e);
    else n_pass++;
    @(negedge clk);
    b_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd0 || m_rsp_valid !== 1'b0)
      $display("[TB] FAIL write_single_rsp: got count=%0d v=%0b want 0 0", dut.count, m_rsp_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    m_req_valid = 1'b1; m_req_addr = 32'h0000_3000;
    exp_q.push_back(32'h3333);
    @(negedge clk);
    m_req_valid = 1'b0;
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h3333; m_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (a_rsp_ready !== 1'b0 || m_rsp_valid !== 1'b1 || m_rsp_rdata !== exp_q[0])
        $display("[TB] FAIL bp_hold: got rdy=%0b v=%0b d=%h want rdy=0 v=1 d=%h",
                 a_rsp_ready, m_rsp_valid, m_rsp_rdata, exp_q[0]);
      else n_pass++;
      @(negedge clk);
    end
    m_rsp_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (a_rsp_ready !== 1'b1 || m_rsp_rdata !== e)
      $display("[TB] FAIL bp_release: got rdy=%0b d=%h want rdy=1 d=%h", a_rsp_ready, m_rsp_rdata, e);
    else n_pass++;
    @(negedge clk);
    a_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd0) $display("[TB] FAIL bp_popped: got %0d want 0", dut.count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    m_req_valid = 1'b1; m_req_addr = 32'h0000_4000;
    @(negedge clk);
    @(negedge clk);
    m_req_valid = 1'b0;
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h5555; m_rsp_ready = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd2 || m_rsp_valid !== 1'b1)
      $display("[TB] FAIL rstmid_before: got count=%0d v=%0b want 2 1", dut.count, m_rsp_valid);
    else n_pass++;
    m_rsp_ready = 1'b1;
    resetn = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd0 || m_rsp_valid !== 1'b0 || a_rsp_ready !== 1'b0)
      $display("[TB] FAIL rstmid_async: got count=%0d v=%0b rdy=%0b want 0 0 0",
               dut.count, m_rsp_valid, a_rsp_ready);
    else n_pass++;
    a_rsp_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_req_valid = 1'b1; m_req_addr = 32'h0000_6000;
    #1;
    n_total++;
    if (m_req_ready !== 1'b1 || a_req_valid !== 1'b1)
      $display("[TB] FAIL rstmid_accept: got rdy=%0b v=%0b want 1 1", m_req_ready, a_req_valid);
    else n_pass++;
    exp_q.push_back(32'h6666);
    @(negedge clk);
    m_req_valid = 1'b0;
    #1;
    n_total++;
    if (dut.count !== 3'd1) $display("[TB] FAIL rstmid_count: got %0d want 1", dut.count);
    else n_pass++;
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h6666;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== e)
      $display("[TB] FAIL rstmid_rsp: got v=%0b d=%h want v=1 d=%h", m_rsp_valid, m_rsp_rdata, e);
    else n_pass++;
    @(negedge clk);
    a_rsp_valid = 1'b0;
  endtask

  task automatic test_err();
    b_rsp_valid = 1'b1; b_rsp_rdata = 32'h7777; m_rsp_ready = 1'b1;
    #1;
    n_total++;
    if ({b_rsp_ready, m_rsp_valid, err} !== 3'b000)
      $display("[TB] FAIL err_stray_same_cycle: got %b want 000", {b_rsp_ready, m_rsp_valid, err});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
`ifdef DEMUX_ERR_EN
      n_total++;
      if (err !== 1'b1 || b_rsp_ready !== 1'b0)
        $display("[TB] FAIL err_sticky: got err=%0b rdy=%0b want err=1 rdy=0", err, b_rsp_ready);
      else n_pass++;
`else
      n_total++;
      if (err !== 1'b0 || b_rsp_ready !== 1'b0)
        $display("[TB] FAIL err_tied: got err=%0b rdy=%0b want err=0 rdy=0", err, b_rsp_ready);
      else n_pass++;
`endif
    end
    b_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    $display("[TB] starting mem_req_demux2 bench");
    test_reset();
    test_order();
    test_full();
    test_write();
    test_backpressure();
    test_reset_mid();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_req_demux2.md
Name: mem_req_demux2

Overview:
- Splits one in-order memory request stream into two target ports, A and B.
- Port A is cached memory and port B is the uncached/MMIO region, selected by address.
- Tracks outstanding requests in order and merges the two response streams back into one in-order stream.
- Sits between the CPU data-side memory stage and the cache / uncached bridge. It is the 1-to-2 counterpart of the 2-to-1 source selection used on the datapath.

Parameters:
- AW, 32, address width
- DW, 32, data width (DW/8 byte strobes)
- DEPTH, 4, maximum outstanding requests (power of two, ≥2)
- B_MASK, 32'hE000_0000, address bits compared for port-B decode
- B_MATCH, 32'hA000_0000, value selecting port B; (addr & B_MASK)==B_MATCH means B, else A

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m_req_valid  in  1  upstream request valid
- m_req_ready  out  1  upstream request accepted
- m_req_addr  in  AW  request address
- m_req_wr  in  1  1=write, 0=read
- m_req_wstrb  in  DW/8  write byte strobes
- m_req_wdata  in  DW  write data
- m_rsp_valid  out  1  upstream response valid
- m_rsp_ready  in  1  upstream can take response
- m_rsp_rdata  out  DW  response read data (0 for writes)
- a_req_valid/ready/addr/wr/wstrb/wdata  out/in/out/out/out/out  1/1/AW/1/DW/8/DW  port-A request
- a_rsp_valid/ready/rdata  in/out/in  1/1/DW  port-A response
- b_req_*, b_rsp_*  same as port A  port-B request/response
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (resetn=0, asynchronous) clears:
  - route FIFO to empty, count=0, rd/wr pointers=0, err=0.
  - The request side keeps its combinational outputs, but a/b_req_valid=0 when m_req_valid=0.
  - m_rsp_valid=0, a/b_rsp_ready=0.
- Decode: sel_b = ((m_req_addr & B_MASK) == B_MATCH).
- Request path is combinational, with zero added latency:
  - a_req_valid = m_req_valid & ~sel_b & ~full; b_req_valid = m_req_valid & sel_b & ~full.
  - addr/wr/wstrb/wdata are broadcast to both ports unchanged.
  - m_req_ready = ~full & (sel_b ? b_req_ready : a_req_ready).
  - m_req_ready does not depend on m_req_valid.
- Accept = m_req_valid & m_req_ready. On accept, push sel_b into the route FIFO at wr_ptr, wr_ptr++ (wraps mod DEPTH), count++.
- full = (count==DEPTH). When full, accept is blocked even if a pop occurs in the same cycle (no push-through).
- Response path is in order:
  - head = FIFO[rd_ptr], valid only when count>0.
  - m_rsp_valid = (count>0) & (head ? b_rsp_valid : a_rsp_valid).
  - m_rsp_rdata = head ? b_rsp_rdata : a_rsp_rdata.
  - a_rsp_ready = (count>0) & ~head & m_rsp_ready; b_rsp_ready = (count>0) & head & m_rsp_ready.
  - The non-head target's response is back-pressured (ready=0) until it becomes head.
- Pop on m_rsp_valid & m_rsp_ready: rd_ptr++ (wraps), count--.
- Simultaneous push and pop with count<DEPTH: count unchanged, both pointers advance.
- Empty (count=0): m_rsp_valid=0 and both rsp_ready=0; stray target responses are held, never dropped.
- Every accepted request, read or write, produces exactly one response from its target.
- Reset asserted mid-transaction discards all tracking. Targets must be reset by the same resetn.

Optional Feature:
- Macro: DEMUX_ERR_EN.
- Defined:
  - Per-port outstanding counters (cnt_a, cnt_b, width clog2(DEPTH)+1) are maintained.
  - err is set, and stays set until reset, when a_rsp_valid=1 with cnt_a==0, or b_rsp_valid=1 with cnt_b==0.
  - err is registered and asserts one cycle after the offending sample.
- Undefined: no counters; err tied to 0.

Test Plan:
- Read 0x0000_1000 then read 0xA000_0004, with A response rdata=0x1111 delayed 5 cycles and B response rdata=0x2222 immediate.
  -> b_rsp_ready held 0 until A's response pops; m_rsp delivers 0x1111 then 0x2222.
- Issue 4 back-to-back reads to A with no responses.
  -> 4 accepts, then m_req_ready=0 with count=4. One response pops; the next request is accepted the following cycle, not in the pop cycle.
- Write 0xA000_0010, wstrb=4'b0011, wdata=0xDEAD_BEEF.
  -> only b_req_valid=1 with fields unchanged; one response with m_rsp_rdata=0.
- m_rsp_ready=0 for 3 cycles while A response is valid.
  -> a_rsp_ready=0 and the data is held stable; pops on the first cycle m_rsp_ready=1.
- resetn pulsed low mid-cycle with 2 requests outstanding.
  -> count=0, m_rsp_valid=0 immediately without waiting for a clock; the next request is accepted normally.
- DEMUX_ERR_EN build: b_rsp_valid=1 with nothing outstanding.
  -> err=1 next cycle and stays 1; b_rsp_ready=0 throughout.
